// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t   : comparator FSM states (IDLE, RUN, DONE)
//   DEFAULT_W : default operand width in bits
package serial_mag_comparator_pkg;

    localparam int unsigned DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mag_cmp_cell.sv
// One-bit magnitude comparison step, applied MSB first.
// Once either flag is set it is sticky and blocks the other from being set.
// Ports:
//   g_in, l_in   : greater/less flags from the more significant bits
//   a_bit, b_bit : current operand bits
//   g_out, l_out : updated greater/less flags
module mag_cmp_cell (
    input  logic g_in,
    input  logic l_in,
    input  logic a_bit,
    input  logic b_bit,
    output logic g_out,
    output logic l_out
);

    assign g_out = g_in | (~l_in & a_bit & ~b_bit);
    assign l_out = l_in | (~g_in & ~a_bit & b_bit);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator. A start in IDLE captures a and b,
// then one bit per cycle is compared MSB first; results are registered on
// entry to DONE and held until the next completed comparison.
// Optional feature macro SERIAL_MAG_COMPARATOR_EARLY_EXIT_EN: leave RUN in the
// cycle the first differing bit is seen instead of always scanning W bits.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, accepted only in IDLE
//   a, b         : unsigned operands (W bits), sampled on accepted start
//   busy         : high while in RUN
//   done         : one-cycle pulse while in DONE
//   gt, lt, eq   : registered comparison results
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         lt,
    output logic         eq
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IdxTop = IW'(W - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          greater_q, greater_d;
    logic          less_q, less_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;

    logic          g_next, l_next;
    logic          last_bit;

    mag_cmp_cell u_cell (
        .g_in  (greater_q),
        .l_in  (less_q),
        .a_bit (a_q[idx_q]),
        .b_bit (b_q[idx_q]),
        .g_out (g_next),
        .l_out (l_next)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        greater_d = greater_q;
        less_d    = less_q;
        idx_d     = idx_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        last_bit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    a_d       = a;
                    b_d       = b;
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                    idx_d     = IdxTop;
                end
            end
            RUN: begin
                greater_d = g_next;
                less_d    = l_next;
                idx_d     = idx_q - IW'(1);
`ifdef SERIAL_MAG_COMPARATOR_EARLY_EXIT_EN
                // First differing bit decides the result; remaining bits cannot change it.
                last_bit  = (idx_q == '0) | g_next | l_next;
`else
                last_bit  = (idx_q == '0);
`endif
                if (last_bit) begin
                    state_d = DONE;
                    idx_d   = IdxTop;
                    gt_d    = g_next;
                    lt_d    = l_next;
                    eq_d    = ~g_next & ~l_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            idx_q     <= IdxTop;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            greater_q <= greater_d;
            less_q    <= less_d;
            idx_q     <= idx_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator (W=4): stimulus pushes expected
// results and the done edge; a monitor pops and compares on every done pulse.
module tb_serial_mag_comparator;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, gt, lt, eq;

    serial_mag_comparator #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   done_edge;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edges from the start-driving edge to the done edge.
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int k;
        k = W;
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i] != y[i]) begin
                k = W - i;
                break;
            end
        end
`ifdef SERIAL_MAG_COMPARATOR_EARLY_EXIT_EN
        return k + 1;
`else
        return W + 1;
`endif
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("gt", int'(gt), int'(e.gt));
                chk("lt", int'(lt), int'(e.lt));
                chk("eq", int'(eq), int'(e.eq));
                chk("onehot", int'(gt) + int'(lt) + int'(eq), 1);
                chk("done_edge", cyc, e.done_edge);
            end
        end
    end

    // Called just after a posedge; returns just after the edge leaving DONE.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input bit mid_start, input bit expect_done);
        exp_t e;
        bit   seen;
        if (expect_done) begin
            e.gt        = (ta > tb_v);
            e.lt        = (ta < tb_v);
            e.eq        = (ta == tb_v);
            e.done_edge = cyc + exp_lat(ta, tb_v);
            exp_q.push_back(e);
        end
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (mid_start) begin
            a     = 4'd15;
            b     = 4'd0;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, d0;
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_gt", int'(gt), 0);
        chk("rst_lt", int'(lt), 0);
        chk("rst_eq", int'(eq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: equal operands, full scan either way
        b0 = busy_cyc;
        run_cmp(4'd9, 4'd9, 1'b0, 1'b1);
        chk("t1_busy_cycles", busy_cyc - b0, 4);
        chk("t1_eq_held", int'(eq), 1);

        // Test 2: MSB decides
        run_cmp(4'd8, 4'd7, 1'b0, 1'b1);
        chk("t2_gt_held", int'(gt), 1);

        // Test 3: second start while busy must be ignored
        d0 = done_cnt;
        run_cmp(4'd3, 4'd12, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("t3_done_pulses", done_cnt - d0, 1);
        chk("t3_lt_held", int'(lt), 1);
        chk("t3_busy_idle", int'(busy), 0);

        // Test 4: reset mid-RUN aborts
        d0    = done_cnt;
        a     = 4'd6;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_gt", int'(gt), 0);
        chk("t4_lt", int'(lt), 0);
        chk("t4_eq", int'(eq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_eq_after", int'(eq), 0);

        // Test 5: exhaustive, back-to-back; first start after reset must work
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_cmp(W'(i), W'(j), 1'b0, 1'b1);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
